// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: physical register tag type, the no-destination tag,
// and the broadcast record seen by the RS, ROB and PR file.
package cdb_arbiter_pkg;

   localparam int NUM_FU     = 5;
   localparam int PHYS_REG_W = 7;
   localparam int CDB_DATA_W = 64;
   localparam int CDB_SRC_W  = $clog2(NUM_FU);

   typedef logic [PHYS_REG_W-1:0] phys_reg_t;

   // Tag carried by stores and non-linking branches: nothing to write back.
   localparam phys_reg_t DUMMY_REG = 7'h7F;

   typedef struct packed {
      logic                  valid;
      phys_reg_t             tag;
      logic [CDB_DATA_W-1:0] data;
      logic [CDB_SRC_W-1:0]  src;
   } cdb_t;

endpackage

// File: rtl/cdb_fifo.sv
// Completion buffer for one functional unit: a small circular FIFO of
// {tag, data}. Results with no destination register are accepted and dropped.
module cdb_fifo
   import cdb_arbiter_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              push,
   input  phys_reg_t         push_tag,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic              ready,
   output logic              nonempty,
   output phys_reg_t         head_tag,
   output logic [DATA_W-1:0] head_data
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0]  head_reg, tail_reg;
   logic [CNT_W-1:0]  count_reg;
   phys_reg_t         tag_mem  [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic              push_en, pop_en;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Readiness looks only at the registered count; a same-cycle pop earns no credit.
   assign ready     = (count_reg != CNT_W'(DEPTH));
   assign nonempty  = (count_reg != '0);
   assign push_en   = push & ready & (push_tag != DUMMY_REG);
   assign pop_en    = pop & nonempty;
   assign head_tag  = tag_mem[head_reg];
   assign head_data = data_mem[head_reg];

   always_ff @(posedge clock) begin
      if (push_en) begin
         tag_mem[tail_reg]  <= push_tag;
         data_mem[tail_reg] <= push_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (push_en) tail_reg <= ptr_inc(tail_reg);
         if (pop_en)  head_reg <= ptr_inc(head_reg);
         if (push_en && !pop_en)      count_reg <= count_reg + CNT_W'(1);
         else if (pop_en && !push_en) count_reg <= count_reg - CNT_W'(1);
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: per-FU completion buffers drained round-robin onto
// a registered single-result broadcast. Squash flushes everything but rr_ptr.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = NUM_FU,
   parameter int BUF_DEPTH = 2,
   parameter int DATA_W    = 64,
   localparam int SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           squash,
   input  logic      [NUM_REQ-1:0]             fu_valid,
   input  phys_reg_t [NUM_REQ-1:0]             fu_tag,
   input  logic      [NUM_REQ-1:0][DATA_W-1:0] fu_data,
   output logic      [NUM_REQ-1:0]             fu_ready,
   output logic                           cdb_valid,
   output phys_reg_t                      cdb_tag,
   output logic [DATA_W-1:0]              cdb_data,
   output logic [SRC_W-1:0]               cdb_src
);

   logic [NUM_REQ-1:0] nonempty;
   logic [NUM_REQ-1:0] pop;
   phys_reg_t          head_tag  [NUM_REQ];
   logic [DATA_W-1:0]  head_data [NUM_REQ];

   logic               grant_valid;
   logic [SRC_W-1:0]   grant_idx;
   logic [SRC_W-1:0]   rr_ptr_reg;
   logic               cdb_valid_reg;
   phys_reg_t          cdb_tag_reg;
   logic [DATA_W-1:0]  cdb_data_reg;
   logic [SRC_W-1:0]   cdb_src_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_fifo
         assign pop[gi] = grant_valid && (grant_idx == SRC_W'(gi));

         cdb_fifo #(
            .DEPTH  (BUF_DEPTH),
            .DATA_W (DATA_W)
         ) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .flush     (squash),
            .push      (fu_valid[gi]),
            .push_tag  (fu_tag[gi]),
            .push_data (fu_data[gi]),
            .pop       (pop[gi]),
            .ready     (fu_ready[gi]),
            .nonempty  (nonempty[gi]),
            .head_tag  (head_tag[gi]),
            .head_data (head_data[gi])
         );
      end
   endgenerate

   // First non-empty buffer at or after rr_ptr, wrapping around.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!grant_valid && nonempty[(int'(rr_ptr_reg) + k) % NUM_REQ]) begin
            grant_valid = 1'b1;
            grant_idx   = SRC_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr_reg <= '0;
      end else if (grant_valid && !squash) begin
         rr_ptr_reg <= (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset || squash || !grant_valid) begin
         cdb_valid_reg <= 1'b0;
         cdb_tag_reg   <= DUMMY_REG;
         cdb_data_reg  <= '0;
         cdb_src_reg   <= '0;
      end else begin
         cdb_valid_reg <= 1'b1;
         cdb_tag_reg   <= head_tag[grant_idx];
         cdb_data_reg  <= head_data[grant_idx];
         cdb_src_reg   <= grant_idx;
      end
   end

   assign cdb_valid = cdb_valid_reg;
   assign cdb_tag   = cdb_tag_reg;
   assign cdb_data  = cdb_data_reg;
   assign cdb_src   = cdb_src_reg;

endmodule
